// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with write-through bypass and a
// per-register pending (scoreboard) bit plus a running count of pending registers.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREAD*ADDR_W-1:0]   ra,
  output logic [NREAD*DATA_W-1:0]   rd,
  output logic [NREAD-1:0]          rbusy,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [ADDR_W-1:0]         wa0,
  input  logic [ADDR_W-1:0]         wa1,
  input  logic [DATA_W-1:0]         wd0,
  input  logic [DATA_W-1:0]         wd1,
  input  logic [31:0]               wpc0,
  input  logic [31:0]               wpc1,
  input  logic                      iss_en,
  input  logic [ADDR_W-1:0]         iss_addr,
  output logic [ADDR_W:0]           pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH] = '{default: '0};
  logic [DEPTH-1:0]  pend_reg = '0;
  logic [DEPTH-1:0]  pend_next;
  logic [ADDR_W:0]   cnt_reg = '0;
  logic [ADDR_W:0]   cnt_next;

  logic act0, act1, com0, iss_act;
  logic inc, dec0, dec1;

  // A port is "active" only when it will really commit; register 0 and reset excluded.
  assign act0    = we0 && (wa0 != '0) && !reset;
  assign act1    = we1 && (wa1 != '0) && !reset;
  assign com0    = act0 && !(act1 && (wa1 == wa0));
  assign iss_act = iss_en && (iss_addr != '0) && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : pend_g
      if (gi == 0) begin : zero_g
        assign pend_next[gi] = 1'b0;
      end else begin : live_g
        // Set beats clear when an issue and a write land on the same register.
        assign pend_next[gi] = (iss_act && (iss_addr == ADDR_W'(gi))) ||
                               (pend_reg[gi] &&
                                !(act0 && (wa0 == ADDR_W'(gi))) &&
                                !(act1 && (wa1 == ADDR_W'(gi))));
      end
    end
  endgenerate

  // Incremental count keeps pend_cnt equal to the popcount without an adder tree.
  always_comb begin
    inc  = iss_act && !pend_reg[iss_addr];
    dec0 = act0 && pend_reg[wa0] && !(iss_act && (iss_addr == wa0)) &&
           !(act1 && (wa1 == wa0));
    dec1 = act1 && pend_reg[wa1] && !(iss_act && (iss_addr == wa1));
    cnt_next = cnt_reg + {{ADDR_W{1'b0}}, inc}
                       - {{ADDR_W{1'b0}}, dec0}
                       - {{ADDR_W{1'b0}}, dec1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
      if (com0) mem_reg[wa0] <= wd0;
      if (act1) mem_reg[wa1] <= wd1;
`ifndef SYNTHESIS
      if (com0) $display("%0t@%h: $%0d <= %h", $time, wpc0, wa0, wd0);
      if (act1) $display("%0t@%h: $%0d <= %h", $time, wpc1, wa1, wd1);
`endif
    end
  end

  assign pend_cnt = cnt_reg;

  generate
    for (gi = 0; gi < NREAD; gi++) begin : rd_g
      logic [ADDR_W-1:0] addr;
      logic              hit0, hit1;
      assign addr = ra[gi*ADDR_W +: ADDR_W];
      assign hit0 = act0 && (wa0 == addr);
      assign hit1 = act1 && (wa1 == addr);
      assign rd[gi*DATA_W +: DATA_W] = (addr == '0) ? '0 :
                                       hit1 ? wd1 :
                                       hit0 ? wd0 : mem_reg[addr];
      assign rbusy[gi] = pend_reg[addr] && !hit0 && !hit1;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: the driver predicts every cycle's outputs from
// an array model, a separate monitor pops the predictions and compares them.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 2;
  localparam int DEPTH  = 32;

  logic                    clk;
  logic                    reset;
  logic [NREAD*ADDR_W-1:0] ra;
  logic [NREAD*DATA_W-1:0] rd;
  logic [NREAD-1:0]        rbusy;
  logic                    we0, we1;
  logic [ADDR_W-1:0]       wa0, wa1;
  logic [DATA_W-1:0]       wd0, wd1;
  logic [31:0]             wpc0, wpc1;
  logic                    iss_en;
  logic [ADDR_W-1:0]       iss_addr;
  logic [ADDR_W:0]         pend_cnt;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .wpc0(wpc0), .wpc1(wpc1), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                      id;
    bit                      rst;
    logic [NREAD*DATA_W-1:0] rd;
    logic [NREAD-1:0]        busy;
    logic [ADDR_W:0]         cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_pend [DEPTH];

  // Expected outputs come from the model state before this cycle's edge, then the
  // model absorbs the cycle's writes/issues as the edge would.
  task automatic step(input bit r,
                      input bit e0, input int a0, input logic [31:0] d0,
                      input bit e1, input int a1, input logic [31:0] d1,
                      input bit ie, input int ia, input int r0, input int r1);
    exp_t e;
    int   n;
    int   addr;
    @(negedge clk);
    reset = r; we0 = e0; wa0 = a0[ADDR_W-1:0]; wd0 = d0;
    we1 = e1; wa1 = a1[ADDR_W-1:0]; wd1 = d1;
    iss_en = ie; iss_addr = ia[ADDR_W-1:0];
    wpc0 = 32'h0000_1000 + txn * 8;
    wpc1 = 32'h0000_1004 + txn * 8;
    ra = {r1[ADDR_W-1:0], r0[ADDR_W-1:0]};

    e.id = txn; e.rst = r; e.rd = '0; e.busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      addr = (k == 0) ? r0 : r1;
      if (addr == 0) begin
        e.rd[k*DATA_W +: DATA_W] = '0;
      end else if (!r && e1 && a1 == addr) begin
        e.rd[k*DATA_W +: DATA_W] = d1;
      end else if (!r && e0 && a0 == addr) begin
        e.rd[k*DATA_W +: DATA_W] = d0;
      end else begin
        e.rd[k*DATA_W +: DATA_W] = m_regs[addr];
        e.busy[k] = m_pend[addr];
      end
    end
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_pend[i]) n++;
    e.cnt = n[ADDR_W:0];
    sb.push_back(e);

    if (r) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (e0 && a0 != 0) begin m_regs[a0] = d0; m_pend[a0] = 1'b0; end
      if (e1 && a1 != 0) begin m_regs[a1] = d1; m_pend[a1] = 1'b0; end
      if (ie && ia != 0) m_pend[ia] = 1'b1;
    end
    txn++;
  endtask

  task automatic idle(input int r0, input int r1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  function automatic int rnd_addr();
    if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, DEPTH - 1));
  endfunction

  exp_t m;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        m = sb.pop_front();
        checks++;
        if (pend_cnt !== m.cnt) begin
          failures++;
          $display("FAIL pend_cnt txn=%0d got=%0d exp=%0d", m.id, pend_cnt, m.cnt);
        end
        if (!m.rst) begin
          for (int k = 0; k < NREAD; k++) begin
            checks++;
            if (rd[k*DATA_W +: DATA_W] !== m.rd[k*DATA_W +: DATA_W]) begin
              failures++;
              $display("FAIL rd[%0d] txn=%0d got=%h exp=%h", k, m.id,
                       rd[k*DATA_W +: DATA_W], m.rd[k*DATA_W +: DATA_W]);
            end
            checks++;
            if (rbusy[k] !== m.busy[k]) begin
              failures++;
              $display("FAIL rbusy[%0d] txn=%0d got=%b exp=%b", k, m.id, rbusy[k], m.busy[k]);
            end
          end
        end
        $display("txn %0d rst=%0b rd=%h rbusy=%b pend_cnt=%0d", m.id, m.rst, rd, rbusy, pend_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout txn=%0d", txn);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    reset = 1'b0; we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    wpc0 = '0; wpc1 = '0; iss_en = 0; iss_addr = '0; ra = '0;

    // Power-up contents, then a reset that swallows a write pair and an issue.
    idle(1, 31);
    step(1, 1, 9, 32'hDEAD, 1, 10, 32'hBEEF, 1, 11, 9, 10);
    idle(9, 10);
    idle(11, 0);

    // Write-through bypass and store.
    step(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 5);
    // Same-address dual write: port 1 wins.
    step(0, 1, 7, 32'hAAAA, 1, 7, 32'hBBBB, 0, 0, 7, 0);
    idle(7, 0);
    // Issue, busy, bypass clears busy, write clears pending.
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    idle(0, 3);
    step(0, 1, 3, 32'h3333, 0, 0, 0, 0, 0, 0, 3);
    idle(0, 3);
    // Issue and write to the same register in one cycle: set wins.
    step(0, 0, 0, 0, 1, 4, 32'h4444, 1, 4, 0, 0);
    idle(4, 4);
    idle(4, 4);
    // Register 0 ignores writes and issues.
    step(0, 1, 0, 32'h5, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);
    // Reset drops outstanding issues; later writes commit normally.
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    idle(1, 2);
    idle(3, 5);
    step(0, 1, 1, 32'h1111, 1, 2, 32'h2222, 0, 0, 1, 2);
    idle(1, 2);

    // Randomized traffic concentrated on a few registers to force collisions.
    for (int t = 0; t < 400; t++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), rnd_addr(), $urandom,
           1'($urandom_range(0, 1)), rnd_addr(), $urandom,
           ($urandom_range(0, 2) != 0), rnd_addr(), rnd_addr(), rnd_addr());
    end
    idle(0, 0);

    @(negedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
